string_edit_ctrl: RTL

- Sequences a 7-bit character input stream into an 11-character (77-bit) string buffer.
- Decodes edit commands: delete, enter and tilde prefix.
- On enter, hands off the completed string to a downstream consumer using a valid/ready handshake.
- Sits between the keypad/character decoder and the string display/transmit path, and owns all buffer state.

---
 rtl/string_edit_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/string_edit_ctrl.sv
// string_edit_ctrl: turns a strobed 7-bit character stream into an
// 11-character string buffer with delete, enter and tilde-prefix editing,
// and hands the committed string downstream.
//
// Naming: the character strobe and the buffer output are called new_strobe
// and string_buf because the bare names "new" and "string" are reserved words.
//
// Handshake: out_valid is high for the whole SEND state, and the string and len
// are held stable while it is high. A transfer happens on every rising clock
// edge where out_valid and out_ready are both high. out_valid never drops
// without a transfer, except on reset. out_ready has no effect while out_valid
// is low.
module string_edit_ctrl #(
  parameter int         MAX_CHARS  = 11,
  parameter logic [6:0] DEL_CODE   = 7'b0001000,
  parameter logic [6:0] ENTER_CODE = 7'b0010000,
  parameter logic [6:0] TILDE_CODE = 7'b0111111,
  parameter logic [6:0] N_CODE     = 7'b0111011,
  parameter logic [6:0] ENYE_CODE  = 7'b1011101
) (
  input  logic                             clk,
  input  logic                             btn1,
  input  logic                             new_strobe,
  input  logic [6:0]                       char,
  input  logic                             out_ready,
  output logic [7*MAX_CHARS-1:0]           string_buf,
  output logic [$clog2(MAX_CHARS+1)-1:0]   len,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             tilde_pend,
  output logic                             overflow,
  output logic [1:0]                       dbg_state
);

  localparam int             LW      = $clog2(MAX_CHARS + 1);
  localparam logic [LW-1:0]  LEN_MAX = LW'(MAX_CHARS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TILDE = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;

  // Synchronizer and edge detector for the asynchronous strobe.
  logic s1, s2, s3;
  logic acc;

  logic [1:0]    state_r, state_n;
  logic [LW-1:0] len_r;
  logic [LW-1:0] pop_idx;
  logic [6:0]    slots [MAX_CHARS];

  // Decoded buffer actions for the current cycle.
  logic          do_push;
  logic          do_pop;
  logic          do_clear;
  logic          do_ovf;
  logic [6:0]    push_code;
  logic          has_room;
  logic          not_empty;

  assign acc       = s2 & ~s3;
  assign has_room  = (len_r < LEN_MAX);
  assign not_empty = (len_r != '0);
  assign pop_idx   = len_r - LW'(1);

  // Two-flop synchronizer plus one edge flop; acc fires once per strobe level.
  always_ff @(posedge clk or negedge btn1) begin
    if (!btn1) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= new_strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Command decode: choose the buffer action and the next state.
  always_comb begin
    state_n   = state_r;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_clear  = 1'b0;
    do_ovf    = 1'b0;
    push_code = char;
    case (state_r)
      IDLE: begin
        if (acc && (char != 7'd0)) begin
          if (char == DEL_CODE) begin
            do_pop = not_empty;
          end else if (char == ENTER_CODE) begin
            if (not_empty) state_n = SEND;
          end else if (char == TILDE_CODE) begin
            state_n = TILDE;
          end else begin
            do_push = has_room;
            do_ovf  = ~has_room;
          end
        end
      end
      TILDE: begin
        if (acc && (char != 7'd0)) begin
          // Any command except a repeated tilde consumes the prefix.
          state_n = IDLE;
          if (char == N_CODE) begin
            push_code = ENYE_CODE;
            do_push   = has_room;
            do_ovf    = ~has_room;
          end else if (char == DEL_CODE) begin
            state_n = IDLE;
          end else if (char == TILDE_CODE) begin
            state_n = TILDE;
          end else if (char == ENTER_CODE) begin
            if (not_empty) state_n = SEND;
          end else begin
            do_push = has_room;
            do_ovf  = ~has_room;
          end
        end
      end
      SEND: begin
        // Strobes are dropped here; only the handshake moves us on.
        if (out_ready) begin
          do_clear = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, length and overflow pulse registers.
  always_ff @(posedge clk or negedge btn1) begin
    if (!btn1) begin
      state_r  <= IDLE;
      len_r    <= '0;
      overflow <= 1'b0;
    end else begin
      state_r  <= state_n;
      overflow <= do_ovf;
      if (do_clear)     len_r <= '0;
      else if (do_push) len_r <= len_r + LW'(1);
      else if (do_pop)  len_r <= pop_idx;
    end
  end

  // Character slots: append at len, clear at len-1, wipe all on handoff.
  always_ff @(posedge clk or negedge btn1) begin
    if (!btn1) begin
      for (int i = 0; i < MAX_CHARS; i++) slots[i] <= 7'd0;
    end else begin
      for (int i = 0; i < MAX_CHARS; i++) begin
        if (do_clear)                           slots[i] <= 7'd0;
        else if (do_push && (len_r == LW'(i)))  slots[i] <= push_code;
        else if (do_pop && (pop_idx == LW'(i))) slots[i] <= 7'd0;
      end
    end
  end

  // Character 0 occupies the most significant 7 bits of the string.
  for (genvar g = 0; g < MAX_CHARS; g++) begin : g_pack
    assign string_buf[7*(MAX_CHARS-g)-1 -: 7] = slots[g];
  end

  assign len        = len_r;
  assign out_valid  = (state_r == SEND);
  assign busy       = (state_r == SEND);
  assign tilde_pend = (state_r == TILDE);
  assign dbg_state  = state_r;

endmodule
